// File: rtl/shift_sequencer_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer: FSM state codes and default widths.
package shift_sequencer_ctrl_pkg;

  localparam int SW_DEF = 26;
  localparam int EW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_ctrl_bit_reverse_mux.sv
// Select-controlled bit reversal; lets left shifts reuse the right-shift datapath.
module bit_reverse_mux #(
  parameter int SW = 26
) (
  input  logic          sel,
  input  logic [SW-1:0] in_d,
  output logic [SW-1:0] out_d
);

  for (genvar j = 0; j < SW; j++) begin : g_bit
    assign out_d[j] = sel ? in_d[SW-1-j] : in_d[j];
  end

endmodule

// File: rtl/shift_sequencer_ctrl.sv
// Serial logical shifter controller: one binary-weighted right-shift stage per cycle,
// left shifts wrapped in bit reversal, sticky OR of every discarded bit.
import shift_sequencer_ctrl_pkg::*;

module shift_sequencer_ctrl #(
  parameter int SW = SW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          left_i,
  input  logic [EW-1:0] shamt_i,
  input  logic [SW-1:0] data_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [SW-1:0] data_o,
  output logic          sticky_o
);

  localparam int KW = (EW > 1) ? $clog2(EW) : 1;

  state_e        state;
  logic [SW-1:0] work;
  logic [EW-1:0] amt;
  logic [KW-1:0] k;
  logic          dir;
  logic          stk;

  logic [SW-1:0] load_w;
  logic [SW-1:0] out_w;
  logic [EW-1:0] step;
  logic [SW-1:0] lost_mask;
  logic [SW-1:0] shifted;
  logic          lost;

  bit_reverse_mux #(.SW(SW)) u_rev_load (
    .sel  (left_i),
    .in_d (data_i),
    .out_d(load_w)
  );

  bit_reverse_mux #(.SW(SW)) u_rev_out (
    .sel  (dir),
    .in_d (work),
    .out_d(out_w)
  );

  // Stage k shifts by 2^k; the low 2^k bits fall off and feed the sticky.
  always_comb begin
    step      = EW'(1) << k;
    lost_mask = ~({SW{1'b1}} << step);
    shifted   = work >> step;
    lost      = |(work & lost_mask);
  end

  assign ready_o = (state == ST_IDLE);
  assign busy_o  = ~ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      work     <= '0;
      amt      <= '0;
      k        <= '0;
      dir      <= 1'b0;
      stk      <= 1'b0;
      data_o   <= '0;
      sticky_o <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            work  <= load_w;
            amt   <= shamt_i;
            dir   <= left_i;
            k     <= KW'(EW-1);
            stk   <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (amt[k]) begin
            work <= shifted;
            stk  <= stk | lost;
          end
          if (k == '0) state <= ST_FINISH;
          else         k     <= k - 1'b1;
        end
        ST_FINISH: begin
          data_o   <= out_w;
          sticky_o <= stk;
          done_o   <= 1'b1;
          state    <= ST_IDLE;
        end
        // Unused encoding falls back to IDLE.
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
